// File: rtl/ft_pkg.sv
// Shared fault-tolerance definitions: recovery FSM states, register-file
// sizing helper and the width of the saturating recovery counter.
package ft_pkg;

  typedef enum logic [1:0] {
    REC_IDLE,
    REC_COPY,
    REC_DONE
  } rec_state_e;

  localparam int REC_CNT_W   = 8;
  localparam int REC_CNT_MAX = (1 << REC_CNT_W) - 1;

  // Number of architectural registers addressed by an addr_w-bit index.
  function automatic int num_reg(input int addr_w);
    return 1 << addr_w;
  endfunction

endpackage

// File: rtl/recovery_writer.sv
// Restores the core register file from the checkpoint register file while
// the replay controller walks the register addresses. Each register is
// written once; repeated addresses are dropped via a written-bitmap.
module recovery_writer
  import ft_pkg::*;
#(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter bit SKIP_ZERO  = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  halt_i,
  input  logic                  resume_i,
  input  logic [ADDR_WIDTH-1:0] replay_addr_i,
  output logic [ADDR_WIDTH-1:0] rf_raddr_o,
  input  logic [DATA_WIDTH-1:0] rf_rdata_i,
  output logic                  rf_we_o,
  output logic [ADDR_WIDTH-1:0] rf_waddr_o,
  output logic [DATA_WIDTH-1:0] rf_wdata_o,
  output logic                  core_halt_o,
  output logic                  recovery_done_o,
  output logic                  incomplete_o,
  output logic [REC_CNT_W-1:0]  recovery_cnt_o
);

  localparam int NUM_REG = num_reg(ADDR_WIDTH);
  localparam int CNT_W   = ADDR_WIDTH + 1;

  // Register 0 is pre-marked as written when it is hardwired to zero.
  localparam logic [CNT_W-1:0]   TARGET      = SKIP_ZERO ? CNT_W'(NUM_REG - 1) : CNT_W'(NUM_REG);
  localparam logic [NUM_REG-1:0] BITMAP_INIT = NUM_REG'(SKIP_ZERO);

  rec_state_e             state_q;
  logic                   halt_q;
  logic                   s1_valid_q;
  logic [ADDR_WIDTH-1:0]  s1_addr_q;
  logic [NUM_REG-1:0]     bitmap_q, bitmap_d;
  logic [CNT_W-1:0]       wr_cnt_q, wr_cnt_d;
  logic                   done_q;
  logic                   core_halt_q;
  logic                   incomplete_q;
  logic [REC_CNT_W-1:0]   rec_cnt_q;

  logic write_ok;
  logic completing;
  logic abort_req;
  logic we;

  // Write-stage decision: a fresh address writes unless an abort squashes it;
  // the write that completes the restore always wins over an abort request.
  always_comb begin
    write_ok   = (state_q == REC_COPY) && s1_valid_q && !bitmap_q[s1_addr_q];
    completing = write_ok && ((wr_cnt_q + CNT_W'(1)) == TARGET);
    abort_req  = (state_q == REC_COPY) && (resume_i || !halt_i) && !completing;
    we         = write_ok && !abort_req;
    bitmap_d   = bitmap_q;
    wr_cnt_d   = wr_cnt_q;
    if (we) begin
      bitmap_d[s1_addr_q] = 1'b1;
      wr_cnt_d            = wr_cnt_q + CNT_W'(1);
    end
  end

  assign rf_raddr_o      = replay_addr_i;
  assign rf_we_o         = we;
  assign rf_waddr_o      = we ? s1_addr_q : '0;
  assign rf_wdata_o      = we ? rf_rdata_i : '0;
  assign core_halt_o     = core_halt_q;
  assign recovery_done_o = done_q;
  assign incomplete_o    = incomplete_q;
  assign recovery_cnt_o  = rec_cnt_q;

  // Recovery FSM with its read pipeline stage, bitmap and registered status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= REC_IDLE;
      halt_q       <= 1'b0;
      s1_valid_q   <= 1'b0;
      s1_addr_q    <= '0;
      bitmap_q     <= '0;
      wr_cnt_q     <= '0;
      done_q       <= 1'b0;
      core_halt_q  <= 1'b0;
      incomplete_q <= 1'b0;
      rec_cnt_q    <= '0;
    end else begin
      halt_q <= halt_i;
      done_q <= 1'b0;
      unique case (state_q)
        REC_IDLE: begin
          s1_valid_q <= 1'b0;
          if (halt_i && !halt_q) begin
            state_q     <= REC_COPY;
            core_halt_q <= 1'b1;
            bitmap_q    <= BITMAP_INIT;
            wr_cnt_q    <= '0;
          end
        end
        REC_COPY: begin
          bitmap_q <= bitmap_d;
          wr_cnt_q <= wr_cnt_d;
          if (completing) begin
            state_q    <= REC_DONE;
            done_q     <= 1'b1;
            s1_valid_q <= 1'b0;
            if (rec_cnt_q != REC_CNT_W'(REC_CNT_MAX)) begin
              rec_cnt_q <= rec_cnt_q + REC_CNT_W'(1);
            end
          end else if (abort_req) begin
            state_q      <= REC_IDLE;
            incomplete_q <= 1'b1;
            core_halt_q  <= 1'b0;
            s1_valid_q   <= 1'b0;
          end else begin
            s1_valid_q <= 1'b1;
            s1_addr_q  <= replay_addr_i;
          end
        end
        REC_DONE: begin
          state_q     <= REC_IDLE;
          core_halt_q <= 1'b0;
        end
        default: begin
          state_q <= REC_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_recovery_writer.sv
// Bench for recovery_writer: instance 0 uses the hardwired-zero register,
// instance 1 restores all 32 registers. Expected writes go into per-instance
// queues when addresses are issued; a negedge monitor pops and compares.
module tb_recovery_writer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        haltI   [2];
  logic        resumeI [2];
  logic [4:0]  addrI   [2];
  logic [31:0] rdataI  [2];
  logic [4:0]  raddrO  [2];
  logic        weO     [2];
  logic [4:0]  waddrO  [2];
  logic [31:0] wdataO  [2];
  logic        haltO   [2];
  logic        doneO   [2];
  logic        incO    [2];
  logic [7:0]  cntO    [2];

  logic [36:0] expQ0[$];
  logic [36:0] expQ1[$];

  int checks = 0;
  int errors = 0;
  int doneCnt [2];
  bit prevDone [2];

  recovery_writer #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .SKIP_ZERO(1'b1)) dut0 (
    .clk(clk), .rst(rst), .halt_i(haltI[0]), .resume_i(resumeI[0]),
    .replay_addr_i(addrI[0]), .rf_raddr_o(raddrO[0]), .rf_rdata_i(rdataI[0]),
    .rf_we_o(weO[0]), .rf_waddr_o(waddrO[0]), .rf_wdata_o(wdataO[0]),
    .core_halt_o(haltO[0]), .recovery_done_o(doneO[0]),
    .incomplete_o(incO[0]), .recovery_cnt_o(cntO[0])
  );

  recovery_writer #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .SKIP_ZERO(1'b0)) dut1 (
    .clk(clk), .rst(rst), .halt_i(haltI[1]), .resume_i(resumeI[1]),
    .replay_addr_i(addrI[1]), .rf_raddr_o(raddrO[1]), .rf_rdata_i(rdataI[1]),
    .rf_we_o(weO[1]), .rf_waddr_o(waddrO[1]), .rf_wdata_o(wdataO[1]),
    .core_halt_o(haltO[1]), .recovery_done_o(doneO[1]),
    .incomplete_o(incO[1]), .recovery_cnt_o(cntO[1])
  );

  // Free-running clock, 10 time units per cycle.
  always #5 clk = ~clk;

  // Checkpoint register file model: data = 0xA000_0000 + addr, one cycle read latency.
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      rdataI[k] <= 32'hA000_0000 + {27'd0, raddrO[k]};
    end
  end

  task automatic checkOutput(input string name, input int k,
                             input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s dut%0d: got %h, expected %h", name, k, actual, expected);
    end
  endtask

  function automatic int qSize(input int k);
    return (k == 0) ? expQ0.size() : expQ1.size();
  endfunction

  function automatic logic [36:0] qPop(input int k);
    if (k == 0) return expQ0.pop_front();
    return expQ1.pop_front();
  endfunction

  // Drive one cycle of replay-controller inputs; optionally record the write it should cause.
  task automatic applyStimulus(input int k, input logic h, input logic r,
                               input logic [4:0] a, input bit expWr);
    logic [36:0] e;
    @(posedge clk);
    #1;
    haltI[k]   = h;
    resumeI[k] = r;
    addrI[k]   = a;
    if (expWr) begin
      e = {a, 32'hA000_0000 + {27'd0, a}};
      if (k == 0) expQ0.push_back(e);
      else        expQ1.push_back(e);
    end
    #1;
    checkOutput("raddr_follows_replay", k, {27'd0, raddrO[k]}, {27'd0, a});
  endtask

  // Full recovery: halt rises, addresses 0..31, last address held, halt dropped.
  task automatic runRecovery(input int k, input bit skipZero);
    applyStimulus(k, 1'b1, 1'b0, 5'd0, 1'b0);
    for (int a = 0; a < 32; a++) begin
      applyStimulus(k, 1'b1, 1'b0, 5'(a), (a != 0) || !skipZero);
    end
    repeat (3) applyStimulus(k, 1'b1, 1'b0, 5'd31, 1'b0);
    applyStimulus(k, 1'b0, 1'b0, 5'd31, 1'b0);
  endtask

  // Monitor: pop expected writes on every DUT write and track done pulses and halt release.
  always @(negedge clk) begin
    logic [36:0] e;
    if (rst) begin
      for (int k = 0; k < 2; k++) prevDone[k] = 1'b0;
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (doneO[k]) begin
          doneCnt[k]++;
          checkOutput("halt_during_done", k, {31'd0, haltO[k]}, 32'd1);
        end
        if (prevDone[k]) checkOutput("halt_after_done", k, {31'd0, haltO[k]}, 32'd0);
        prevDone[k] = doneO[k];
        if (weO[k]) begin
          if (qSize(k) == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_write dut%0d: got addr %0d data %h, required no write",
                     k, waddrO[k], wdataO[k]);
          end else begin
            e = qPop(k);
            checkOutput("write_addr", k, {27'd0, waddrO[k]}, {27'd0, e[36:32]});
            checkOutput("write_data", k, wdataO[k], e[31:0]);
          end
        end
      end
    end
  end

  // Directed scenarios followed by the summary line.
  initial begin
    for (int k = 0; k < 2; k++) begin
      haltI[k] = 1'b0; resumeI[k] = 1'b0; addrI[k] = 5'd0; doneCnt[k] = 0;
    end
    #2;
    for (int k = 0; k < 2; k++) begin
      checkOutput("reset_we", k, {31'd0, weO[k]}, 32'd0);
      checkOutput("reset_halt", k, {31'd0, haltO[k]}, 32'd0);
      checkOutput("reset_done", k, {31'd0, doneO[k]}, 32'd0);
      checkOutput("reset_incomplete", k, {31'd0, incO[k]}, 32'd0);
      checkOutput("reset_cnt", k, {24'd0, cntO[k]}, 32'd0);
    end
    @(posedge clk); #1; rst = 1'b0;
    repeat (2) applyStimulus(0, 1'b0, 1'b0, 5'd0, 1'b0);

    $display("[TB] scenario A: normal recovery");
    runRecovery(0, 1'b1);
    checkOutput("A_done_pulses", 0, doneCnt[0], 32'd1);
    checkOutput("A_rec_cnt", 0, {24'd0, cntO[0]}, 32'd1);
    checkOutput("A_halt_released", 0, {31'd0, haltO[0]}, 32'd0);
    checkOutput("A_incomplete", 0, {31'd0, incO[0]}, 32'd0);
    checkOutput("A_all_writes_seen", 0, qSize(0), 32'd0);

    $display("[TB] scenario B: early resume");
    applyStimulus(0, 1'b1, 1'b0, 5'd0, 1'b0);
    for (int a = 0; a <= 10; a++) begin
      applyStimulus(0, 1'b1, 1'b0, 5'(a), (a >= 1) && (a <= 9));
    end
    applyStimulus(0, 1'b1, 1'b1, 5'd10, 1'b0);
    applyStimulus(0, 1'b0, 1'b0, 5'd10, 1'b0);
    applyStimulus(0, 1'b0, 1'b0, 5'd10, 1'b0);
    checkOutput("B_incomplete", 0, {31'd0, incO[0]}, 32'd1);
    checkOutput("B_no_done", 0, doneCnt[0], 32'd1);
    checkOutput("B_rec_cnt", 0, {24'd0, cntO[0]}, 32'd1);
    checkOutput("B_halt_released", 0, {31'd0, haltO[0]}, 32'd0);
    checkOutput("B_all_writes_seen", 0, qSize(0), 32'd0);

    $display("[TB] scenario C: duplicate addresses");
    applyStimulus(0, 1'b1, 1'b0, 5'd1, 1'b0);
    for (int a = 1; a < 32; a++) begin
      applyStimulus(0, 1'b1, 1'b0, 5'(a), 1'b1);
      applyStimulus(0, 1'b1, 1'b0, 5'(a), 1'b0);
    end
    repeat (3) applyStimulus(0, 1'b1, 1'b0, 5'd31, 1'b0);
    applyStimulus(0, 1'b0, 1'b0, 5'd31, 1'b0);
    checkOutput("C_done_pulses", 0, doneCnt[0], 32'd2);
    checkOutput("C_rec_cnt", 0, {24'd0, cntO[0]}, 32'd2);
    checkOutput("C_incomplete_sticky", 0, {31'd0, incO[0]}, 32'd1);
    checkOutput("C_all_writes_seen", 0, qSize(0), 32'd0);

    $display("[TB] scenario D: reset mid-copy");
    applyStimulus(0, 1'b1, 1'b0, 5'd0, 1'b0);
    for (int a = 0; a <= 15; a++) begin
      applyStimulus(0, 1'b1, 1'b0, 5'(a), a >= 1);
    end
    applyStimulus(0, 1'b1, 1'b0, 5'd15, 1'b0);
    @(negedge clk);
    #1;
    rst = 1'b1;
    haltI[0] = 1'b0;
    #1;
    checkOutput("D_we", 0, {31'd0, weO[0]}, 32'd0);
    checkOutput("D_waddr", 0, {27'd0, waddrO[0]}, 32'd0);
    checkOutput("D_wdata", 0, wdataO[0], 32'd0);
    checkOutput("D_halt", 0, {31'd0, haltO[0]}, 32'd0);
    checkOutput("D_done", 0, {31'd0, doneO[0]}, 32'd0);
    checkOutput("D_incomplete", 0, {31'd0, incO[0]}, 32'd0);
    checkOutput("D_rec_cnt", 0, {24'd0, cntO[0]}, 32'd0);
    repeat (2) @(posedge clk);
    #1; rst = 1'b0;
    for (int a = 16; a <= 20; a++) applyStimulus(0, 1'b0, 1'b0, 5'(a), 1'b0);
    checkOutput("D_halt_after", 0, {31'd0, haltO[0]}, 32'd0);
    checkOutput("D_all_writes_seen", 0, qSize(0), 32'd0);

    $display("[TB] scenario E: full register set and saturation");
    runRecovery(1, 1'b0);
    checkOutput("E_first_cnt", 1, {24'd0, cntO[1]}, 32'd1);
    checkOutput("E_all_writes_seen", 1, qSize(1), 32'd0);
    for (int n = 1; n < 255; n++) runRecovery(1, 1'b0);
    checkOutput("E_cnt_255", 1, {24'd0, cntO[1]}, 32'd255);
    runRecovery(1, 1'b0);
    checkOutput("E_cnt_saturated", 1, {24'd0, cntO[1]}, 32'd255);
    checkOutput("E_done_pulses", 1, doneCnt[1], 32'd256);
    checkOutput("E_incomplete", 1, {31'd0, incO[1]}, 32'd0);
    checkOutput("E_all_writes_final", 1, qSize(1), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/recovery_writer.md
RECOVERY_WRITER -- requirements
Module: recovery_writer

Interface
REQ-001 Parameter ADDR_WIDTH, default 5, register address width; NUM_REG = 2**ADDR_WIDTH.
REQ-002 Parameter DATA_WIDTH, default 32, register data width.
REQ-003 Parameter SKIP_ZERO, default 1, when 1 address 0 is never written (hardwired-zero register).
REQ-004 Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- halt_i  input  1  recovery request from the replay controller (level).
- resume_i  input  1  replay sequence finished, from the replay controller.
- replay_addr_i  input  ADDR_WIDTH  replay address from the replay controller.
- rf_raddr_o  output  ADDR_WIDTH  read address to the checkpoint register file.
- rf_rdata_i  input  DATA_WIDTH  checkpoint read data, valid one cycle after rf_raddr_o.
- rf_we_o  output  1  core register file write enable.
- rf_waddr_o  output  ADDR_WIDTH  core register file write address.
- rf_wdata_o  output  DATA_WIDTH  core register file write data.
- core_halt_o  output  1  holds the core pipeline while recovery is in progress.
- recovery_done_o  output  1  one-cycle pulse when all registers are restored.
- incomplete_o  output  1  sticky flag: recovery aborted before all registers were restored.
- recovery_cnt_o  output  8  count of successful recoveries, saturating.

Function
REQ-005 FSM states: IDLE, COPY, DONE.
REQ-006 IDLE -> COPY on a rising edge of halt_i (halt_i=1 while the registered copy halt_q=0).
- On entry: clear the written bitmap and write counter.
- With SKIP_ZERO=1, bit 0 of the bitmap is preset.
REQ-007 rf_raddr_o SHALL equal replay_addr_i combinationally in every state.
REQ-008 In COPY, each cycle registers (replay_addr_i, valid=1) into stage s1.
REQ-009 Write stage: the cycle after s1 valid, rf_we_o=1, rf_waddr_o=s1 address, rf_wdata_o=rf_rdata_i.
- Condition: the bitmap bit for that address is clear.
- Read-to-write latency is exactly 1 cycle.
REQ-010 Duplicate address (bitmap bit set): no write, counter unchanged.
- The replay controller holds its final address for several cycles; this case is normal.
REQ-011 Each performed write sets its bitmap bit and increments the write counter.
- Counter width: ADDR_WIDTH+1 bits, no wrap.
REQ-012 COPY -> DONE in the cycle after the write that makes the counter reach the target.
- Target: NUM_REG-1 when SKIP_ZERO=1, else NUM_REG.
REQ-013 DONE: recovery_done_o=1 for exactly one cycle, recovery_cnt_o increments (saturating at 255), then -> IDLE.
REQ-014 core_halt_o=1 from the COPY entry cycle through the DONE cycle inclusive; 0 otherwise.
REQ-015 Abort: in COPY, if resume_i=1 or halt_i=0 before the target is reached:
- -> IDLE next cycle.
- Set incomplete_o.
- Squash the s1 entry in flight (no write).
- No done pulse, no recovery_cnt_o increment.
REQ-016 resume_i and the completing write in the same cycle: completion wins (DONE, no abort).
REQ-017 halt_i rising in DONE or while already in COPY: ignored; a new recovery requires returning to IDLE first.
REQ-018 rf_we_o SHALL be 0 in IDLE and DONE.

Reset
REQ-019 rst=1 asynchronously forces:
- state IDLE, halt_q=0, s1 valid=0, bitmap/counter 0.
- All outputs 0: rf_we_o, core_halt_o, recovery_done_o, incomplete_o, recovery_cnt_o, rf_waddr_o, rf_wdata_o.
REQ-020 Reset mid-COPY abandons recovery without further writes.
- incomplete_o is cleared only by reset.

Structure
REQ-021 Shared package ft_pkg holds:
- the recovery state enum;
- the NUM_REG constant derivation;
- the 8-bit recovery counter width constant.
REQ-022 Single flat module, no sub-module; the bitmap is a NUM_REG-bit register inside recovery_writer.

Verification (ADDR_WIDTH=5, DATA_WIDTH=32, checkpoint RF preloaded with data = 0xA000_0000 + addr)
REQ-023 Scenario A (normal recovery): halt_i rises, addresses 0..31 replay one per cycle, last address then held for 3 cycles.
- Exactly 31 writes: addr 1..31, data 0xA000_0001..0xA000_001F.
- recovery_done_o pulses once; recovery_cnt_o=1; core_halt_o falls the cycle after done.
REQ-024 Scenario B (early resume): resume_i asserted after address 10 is issued.
- Writes only addr 1..9; no write for 10.
- incomplete_o=1; no done pulse.
REQ-025 Scenario C (duplicates): replay 1,1,2,2,...,31.
- Exactly 31 writes, each address written once.
REQ-026 Scenario D (reset mid-copy): rst asserted mid-cycle at address 15.
- rf_we_o drops immediately; all outputs 0; no later write.
REQ-027 Scenario E (SKIP_ZERO=0 and saturation):
- 32 writes including addr 0.
- After 256 back-to-back recoveries, recovery_cnt_o=255.
